// File: rtl/fifo_stream_unpacker.sv
// Read-side FIFO controller: fetches BITLEN-bit words and unpacks them into
// ELEM_BITS-wide elements on a valid/ready stream, flagging the last element.
module fifo_stream_unpacker #(
  parameter int BITLEN    = 64,
  parameter int ELEM_BITS = 8,
  parameter int LANE_BIT  = 3,
  parameter int LEN_BIT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_BIT-1:0]   len,
  output logic                 busy,
  output logic                 done,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [BITLEN-1:0]    fifo_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [ELEM_BITS-1:0] m_data,
  output logic                 m_last
);

  localparam int LANES = BITLEN / ELEM_BITS;
  localparam logic [LANE_BIT-1:0] LAST_LANE = LANE_BIT'(LANES - 1);
  localparam logic [LEN_BIT-1:0]  ONE       = LEN_BIT'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_STREAM
  } state_t;

  state_t                state_q, state_d;
  logic [BITLEN-1:0]     word_q;
  logic [LANE_BIT-1:0]   lane_q;
  logic [LEN_BIT-1:0]    remaining_q;
  logic                  done_q;

  logic handshake;
  logic final_elem;
  logic cmd_accept;
  logic cmd_empty;

  assign handshake  = m_valid && m_ready;
  assign final_elem = (remaining_q == ONE);
  assign cmd_accept = (state_q == S_IDLE) && start && (len != '0);
  assign cmd_empty  = (state_q == S_IDLE) && start && (len == '0);

  // Next-state and FIFO read strobe. The read is gated by reset so an
  // in-progress fetch never pops a word while the block is being cleared.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fifo_rd_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_accept) state_d = S_FETCH;
      end
      S_FETCH: begin
        fifo_rd_en = !fifo_empty && !rst_n;
        if (fifo_rd_en) state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (handshake) begin
          if (final_elem)               state_d = S_IDLE;
          else if (lane_q == LAST_LANE) state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      lane_q      <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= cmd_empty || ((state_q == S_STREAM) && handshake && final_elem);

      if (cmd_accept) remaining_q <= len;

      if (state_q == S_WAIT) begin
        word_q <= fifo_dout;
        lane_q <= '0;
      end

      // Lane stays put on the last element of a word or command; WAIT rewinds it.
      if ((state_q == S_STREAM) && handshake) begin
        remaining_q <= remaining_q - ONE;
        if (!final_elem && (lane_q != LAST_LANE)) lane_q <= lane_q + 1'b1;
      end
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign m_valid = (state_q == S_STREAM);
  assign m_last  = m_valid && final_elem;
  assign m_data  = m_valid ? word_q[lane_q*ELEM_BITS +: ELEM_BITS] : '0;

endmodule

// File: tb/tb_fifo_stream_unpacker.sv
// Self-checking bench: behavioural FIFO plus a byte-sequence reference model
// for directed and randomized unpack commands.
module tb_fifo_stream_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [63:0] fifo_dout;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;

  always #5 clk = ~clk;

  fifo_stream_unpacker #(
    .BITLEN(64), .ELEM_BITS(8), .LANE_BIT(3), .LEN_BIT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy), .done(done),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  logic [63:0] mem [0:511];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          reads_cnt = 0;
  logic        hold_empty = 1'b0;

  int n_asserts = 0;
  int n_fail    = 0;

  assign fifo_empty = (rd_ptr == wr_ptr) || hold_empty;

  // Behavioural FIFO: read data appears the cycle after an accepted read.
  initial fifo_dout = '0;
  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
      reads_cnt <= reads_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  // Element i of a command is byte (i mod 8) of the (i div 8)-th word it reads.
  function automatic logic [7:0] ref_elem(input int base, input int i);
    logic [63:0] w;
    w = mem[base + i / 8];
    return w[(i % 8) * 8 +: 8];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, m_valid, 1'b0);
    check({tag, "_last"},  m_last, 1'b0);
    check({tag, "_data"},  m_data, 8'h00);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_rd_en"}, fifo_rd_en, 1'b0);
  endtask

  // mode: 0 = always ready, 1 = random ready, 2 = ready low 3 cycles while element 03 shows.
  task automatic run_cmd(input int n, input int mode, input int empty_cycles,
                         input bit poke_start, input int rst_after);
    int          base, reads0, k, t, valid_due, stall, empty_left, hold03;
    bit          exp_done, finished, do_reset, hold, hold_last;
    logic [7:0]  hold_data;
    base = rd_ptr; reads0 = reads_cnt; k = 0; t = 0; valid_due = -1;
    stall = 0; hold03 = 0; finished = 0; do_reset = 0; hold = 0;
    hold_last = 0; hold_data = '0;

    @(negedge clk);
    start      = 1'b1;
    len        = 16'(n);
    empty_left = empty_cycles;
    hold_empty = (empty_left > 0);
    m_ready    = 1'b1;
    exp_done   = (n == 0);

    while (!finished && !do_reset && t < 2000) begin
      @(negedge clk);
      t++;
      start = poke_start && (t == 3);
      len   = start ? 16'd3 : 16'(n);
      if (empty_left > 0) empty_left--;
      hold_empty = (empty_left > 0);
      case (mode)
        1:       m_ready = ($urandom_range(0, 3) != 0);
        2:       begin m_ready = (stall == 0); if (stall > 0) stall--; end
        default: m_ready = 1'b1;
      endcase

      check("done", done, exp_done);
      if (exp_done) begin
        check("busy_at_done", busy, 1'b0);
        finished = 1;
      end
      exp_done = 0;
      check("rd_en_while_empty", fifo_rd_en && fifo_empty, 1'b0);
      if (fifo_rd_en) valid_due = t + 2;
      if (t == valid_due) check("rd_to_valid", m_valid, 1'b1);
      if (hold) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, hold_data);
        check("hold_last", m_last, hold_last);
      end
      hold = 0;

      if (m_valid) begin
        check("valid_overrun", k < n, 1'b1);
        if (k == 2) hold03++;
        if (k < n) begin
          if (m_ready) begin
            check("data", m_data, ref_elem(base, k));
            check("last", m_last, k == n - 1);
            k++;
            if (k == n) exp_done = 1;
            if (mode == 2 && k == 2) stall = 3;
            if (rst_after != 0 && k == rst_after) do_reset = 1;
          end else begin
            hold = 1; hold_data = m_data; hold_last = m_last;
          end
        end
      end
    end

    if (do_reset) begin
      @(negedge clk);
      rst_n   = 1'b1;
      m_ready = 1'b0;
      check("rd_en_in_reset", fifo_rd_en, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      check_idle_outputs("mid_reset");
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("no_done_after_reset", done, 1'b0);
        check("idle_after_reset", busy, 1'b0);
      end
      check("reads_before_reset", reads_cnt - reads0, 1);
    end else if (!finished) begin
      check("timeout", 1'b0, 1'b1);
    end else begin
      check("elem_count", k, n);
      check("reads", reads_cnt - reads0, (n + 7) / 8);
      if (mode == 2) check("stall_03_cycles", hold03, 4);
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        check("post_done", done, 1'b0);
        check("post_busy", busy, 1'b0);
        check("post_valid", m_valid, 1'b0);
      end
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    start   = 1'b0;
    len     = '0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // Single word.
    push(64'h0807060504030201);
    run_cmd(8, 0, 0, 1'b0, 0);

    // Partial final word: bytes 0B..10 dropped.
    push(64'h0807060504030201);
    push(64'h100F0E0D0C0B0A09);
    run_cmd(10, 0, 0, 1'b0, 0);

    // Backpressure on element 03.
    push(64'h0807060504030201);
    run_cmd(8, 2, 0, 1'b0, 0);

    // FIFO held empty after start.
    push(64'h8877665544332211);
    run_cmd(8, 0, 5, 1'b0, 0);

    // Zero length.
    run_cmd(0, 0, 0, 1'b0, 0);

    // Start pulsed while busy is ignored.
    push(64'hF7E6D5C4B3A29180);
    push(64'h0F1E2D3C4B5A6978);
    run_cmd(12, 0, 0, 1'b1, 0);

    // Reset after element 05, then a fresh command reads the next word.
    push(64'h0807060504030201);
    push(64'hCAFEBABEDEADBEEF);
    run_cmd(8, 0, 0, 1'b0, 5);
    run_cmd(8, 0, 0, 1'b0, 0);

    // Randomized commands with random data and random backpressure.
    for (int c = 0; c < 15; c++) begin
      int n;
      n = $urandom_range(1, 40);
      for (int w = 0; w < (n + 7) / 8; w++) push({$urandom, $urandom});
      run_cmd(n, 1, (c % 4 == 0) ? 3 : 0, (c % 3 == 0), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_stream_unpacker.md
# fifo_stream_unpacker

Read-side controller for the on-chip FIFO. It drains BITLEN-bit words through the FIFO's rd_en/empty/dout port and splits each word into ELEM_BITS-wide elements. The elements go out on a valid/ready stream that feeds the compute engine. A start/len command sets how many elements to deliver; the block then flags the final element and pulses done.

## Interface
Parameters:
- BITLEN, 64, FIFO word width; must be a multiple of ELEM_BITS
- ELEM_BITS, 8, output element width
- LANE_BIT, 3, width of lane index; 2^LANE_BIT = BITLEN/ELEM_BITS
- LEN_BIT, 16, width of element count

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-high reset (asserted = 1)
- start  in  1  command strobe, sampled in IDLE only
- len  in  LEN_BIT  element count, sampled with start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at command completion
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO read enable
- fifo_dout  in  BITLEN  FIFO read data; valid the cycle after an accepted read
- m_valid  out  1  element valid
- m_ready  in  1  consumer ready
- m_data  out  ELEM_BITS  element data
- m_last  out  1  high with the final element of a command

## Operation
- State machine has four states: IDLE, FETCH, WAIT, STREAM.
- IDLE:
  - start=1 and len!=0: latch remaining=len and go to FETCH.
  - start=1 and len=0: pulse done next cycle and stay in IDLE.
- FETCH:
  - fifo_rd_en = (state==FETCH) && !fifo_empty && !rst_n. This is combinational.
  - When fifo_rd_en=1, go to WAIT.
  - When the FIFO is empty, stay in FETCH indefinitely.
- WAIT: capture fifo_dout into the word register, set lane=0, go to STREAM.
- STREAM outputs:
  - m_valid=1.
  - m_data = word[lane*ELEM_BITS +: ELEM_BITS]; lane 0 is the LSBs.
  - m_last = (remaining==1).
- STREAM, on handshake (m_valid && m_ready):
  - Decrement remaining.
  - If remaining was 1: go to IDLE and pulse done in the next cycle.
  - Else if lane is the last lane: go to FETCH.
  - Otherwise: increment lane.
- Partial final word: lanes beyond the last element are discarded. No extra FIFO read is issued.
- start while busy is ignored; len is not re-sampled.
- No handshake means m_data, m_last and lane hold stable.
- Reset values: state=IDLE, word=0, lane=0, remaining=0, m_valid=0, m_last=0, m_data=0, done=0, busy=0, fifo_rd_en=0.
- Reset mid-operation:
  - Returns to IDLE with no done pulse.
  - The in-flight word is dropped.
  - FIFO contents are untouched except for any read already accepted before reset.

## Timing
- Start to first rd_en: start in cycle 0 → FETCH in cycle 1 → fifo_rd_en in cycle 1 if FIFO non-empty.
- WAIT in cycle 2 captures fifo_dout. First m_valid in cycle 3.
- Per word: 2 overhead cycles (FETCH+WAIT), then one element per cycle while m_ready=1.
- At m_ready=1 and non-empty FIFO, 8 lanes per word: 10 cycles per word.
- done is asserted the cycle after the handshake with m_last=1. busy falls in that same cycle.
- FIFO reads issued per command = ceil(len / (BITLEN/ELEM_BITS)).
- remaining never underflows; it only decrements on handshake and remaining>=1 in STREAM.
- fifo_rd_en never asserts while fifo_empty=1 or during reset.

## Test plan
- Single word: FIFO holds 0x0807060504030201; start, len=8, m_ready=1.
  - m_data = 01..08 on consecutive cycles; m_last only on 08.
  - Exactly one fifo_rd_en; done one cycle after 08.
- Partial last word: words 0x0807060504030201 and 0x100F0E0D0C0B0A09; len=10.
  - Elements 01..0A in order; m_last on 0A.
  - Exactly 2 reads; bytes 0B..10 dropped; busy low after done.
- Backpressure: len=8, drop m_ready for 3 cycles after element 03.
  - m_valid stays 1, m_data holds 03 for 4 cycles, m_last stays 0.
  - Stream resumes with 04.
- Empty stall: fifo_empty=1 for 5 cycles after start.
  - fifo_rd_en stays 0 and state holds FETCH.
  - After word arrives, first element comes 2 cycles after rd_en.
- Zero length and ignored start:
  - len=0 → done in the next cycle, no rd_en, m_valid never 1.
  - start pulsed while busy leaves remaining and the output sequence unchanged.
- Reset mid-stream: assert rst_n for 1 cycle after element 05 of len=8.
  - All outputs 0 in the next cycle; no done.
  - A new start with len=8 reads the next FIFO word.
